// File: rtl/prg_byte_buffer_pkg.sv
// Shared definitions for the PRG byte buffer: FSM state encodings
// and generator data widths.
package prg_byte_buffer_pkg;

    localparam int PRG_SEED_W  = 32;
    localparam int PRG_VALUE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/prg_byte_buffer_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and a registered head.
// Ports: clk, reset (sync, active high), push/wdata, pop, flush,
//        head (entry at the read pointer), valid (non-empty), count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          vld_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop in the same cycle.
    always_comb begin
        do_push = push && !flush && (cnt_q != FULL);
        do_pop  = pop && vld_q && !flush;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            vld_q <= (cnt_d != '0);
            if (do_push) mem_q[wr_q] <= wdata;
        end
    end

    // A push into an empty FIFO lands at the read pointer, so the byte
    // is visible on head right after the write edge.
    assign head  = mem_q[rd_q];
    assign valid = vld_q;
    assign count = cnt_q;

endmodule

// File: rtl/prg_byte_buffer.sv
// prg_byte_buffer: requests bytes from a start/done PRNG and buffers them
// for a valid/ready consumer.
// Ports: clk, reset (sync, active high); seed_in/seed_load (reseed + flush);
//        prg_start/prg_seed/prg_value/prg_done (generator side);
//        out_data/out_valid/out_ready (consumer); count; timeout_err (sticky).
module prg_byte_buffer
    import prg_byte_buffer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PRG_SEED_W-1:0]   seed_in,
    input  logic                    seed_load,
    output logic                    prg_start,
    output logic [PRG_SEED_W-1:0]   prg_seed,
    input  logic [PRG_VALUE_W-1:0]  prg_value,
    input  logic                    prg_done,
    output logic [PRG_VALUE_W-1:0]  out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [PRG_SEED_W-1:0]   seed_q, seed_d;
    logic [15:0]             tmo_q, tmo_d;
    logic                    err_q, err_d;
    logic                    push;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (state_q)
            // Waiting for done low also covers a reset mid-request.
            IDLE: begin
                if (count < FULL && !prg_done) state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                if (prg_done) begin
                    push    = 1'b1;
                    state_d = RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RELEASE: begin
                if (!prg_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reseed abandons any in-flight request; its result is dropped.
        if (seed_load) begin
            seed_d = seed_in;
            push   = 1'b0;
            if (state_q == REQ || state_q == WAIT) state_d = RELEASE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seed_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    sync_fifo #(
        .WIDTH (PRG_VALUE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (out_ready),
        .flush (seed_load),
        .wdata (prg_value),
        .head  (out_data),
        .valid (out_valid),
        .count (count)
    );

    assign prg_start   = (state_q == REQ);
    assign prg_seed    = seed_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_prg_byte_buffer.sv
// Bench for prg_byte_buffer: cycle table for the handshake, then a
// generator model with a byte scoreboard for fill/drain/reseed/timeout.
module tb_prg_byte_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] seed_in;
    logic        seed_load;
    logic        prg_start;
    logic [31:0] prg_seed;
    logic [7:0]  prg_value;
    logic        prg_done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        timeout_err;

    prg_byte_buffer #(.DEPTH(8), .TIMEOUT(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .seed_in     (seed_in),
        .seed_load   (seed_load),
        .prg_start   (prg_start),
        .prg_seed    (prg_seed),
        .prg_value   (prg_value),
        .prg_done    (prg_done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // ---------------- generator model + scoreboard ----------------
    bit          model_on;
    bit          hang;
    int          hold_len;
    int          m_cnt;
    int          m_left;
    logic [31:0] m_state;
    logic [31:0] m_seed;
    bit          m_reload;
    bit          m_stale;
    logic [7:0]  m_val;
    int          starts;
    logic [7:0]  sb[$];

    task automatic model_reset();
        m_cnt     = 0;
        m_left    = 0;
        prg_done  = 1'b0;
        prg_value = 8'h00;
        m_seed    = 32'h0;
        m_state   = 32'h0;
        m_reload  = 1'b1;
        m_stale   = 1'b0;
        sb.delete();
    endtask

    task automatic model_update();
        if (!model_on) return;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) prg_done = 1'b0;
        end
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                prg_done  = 1'b1;
                prg_value = m_val;
                m_left    = hold_len;
                if (!m_stale) sb.push_back(m_val);
            end
        end
        if (prg_start) begin
            starts++;
            if (!hang) begin
                if (m_reload) m_state = m_seed;
                m_reload = 1'b0;
                m_state  = xs(m_state);
                m_val    = m_state[7:0];
                m_cnt    = 3;
                m_stale  = 1'b0;
            end
        end
    endtask

    // Inputs for the coming edge are already driven when step is called.
    task automatic step();
        if (out_valid && out_ready && !seed_load && !reset) begin
            if (sb.size() == 0) chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            else chk("pop_order", 32'(out_data), 32'(sb.pop_front()));
        end
        @(posedge clk);
        @(negedge clk);
        model_update();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        seed_load = 1'b0;
        out_ready = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic reseed(input logic [31:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        sb.delete();
        m_seed   = s;
        m_reload = 1'b1;
        if (m_cnt > 0) m_stale = 1'b1;
        step();
        seed_load = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input int maxc, input string nm);
        int n;
        n = 0;
        while (32'(count) != target && n < maxc) begin
            step();
            n++;
        end
        chk(nm, 32'(count), 32'(target));
    endtask

    // ---------------- handshake table ----------------
    typedef struct {
        logic        rst;
        logic        sl;
        logic [31:0] seed;
        logic        done;
        logic [7:0]  val;
        logic        rdy;
        logic        e_start;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [3:0]  e_count;
        logic [31:0] e_seed;
    } vec_t;

    localparam bit L = 1'b0;
    localparam bit H = 1'b1;
    localparam logic [31:0] S = 32'h1234_5678;
    localparam int NV = 19;

    vec_t tbl [NV];

    initial begin
        logic [31:0] tmp;
        int n;
        int n2;
        int s0;
        int c0;
        bit ok;

        reset     = 1'b1;
        seed_load = 1'b0;
        seed_in   = 32'h0;
        prg_done  = 1'b0;
        prg_value = 8'h00;
        out_ready = 1'b0;
        model_on  = 1'b0;
        hang      = 1'b0;
        hold_len  = 1;
        starts    = 0;
        m_cnt     = 0;
        m_left    = 0;

        tbl[0]  = '{H, L, 32'h0, L, 8'h00, L, L, L, 8'h00, 4'd0, 32'h0};
        tbl[1]  = '{H, L, 32'h0, L, 8'h00, L, L, L, 8'h00, 4'd0, 32'h0};
        tbl[2]  = '{L, L, 32'h0, L, 8'h00, L, H, L, 8'h00, 4'd0, 32'h0};
        tbl[3]  = '{L, L, 32'h0, L, 8'h00, L, L, L, 8'h00, 4'd0, 32'h0};
        tbl[4]  = '{L, L, 32'h0, H, 8'hA5, L, L, H, 8'hA5, 4'd1, 32'h0};
        tbl[5]  = '{L, L, 32'h0, H, 8'h3C, L, L, H, 8'hA5, 4'd1, 32'h0};
        tbl[6]  = '{L, L, 32'h0, L, 8'h00, L, L, H, 8'hA5, 4'd1, 32'h0};
        tbl[7]  = '{L, L, 32'h0, L, 8'h00, L, H, H, 8'hA5, 4'd1, 32'h0};
        tbl[8]  = '{L, L, 32'h0, L, 8'h00, H, L, L, 8'h00, 4'd0, 32'h0};
        tbl[9]  = '{L, L, 32'h0, H, 8'h5A, L, L, H, 8'h5A, 4'd1, 32'h0};
        tbl[10] = '{L, L, 32'h0, L, 8'h00, L, L, H, 8'h5A, 4'd1, 32'h0};
        tbl[11] = '{L, L, 32'h0, L, 8'h00, L, H, H, 8'h5A, 4'd1, 32'h0};
        tbl[12] = '{L, L, 32'h0, L, 8'h00, L, L, H, 8'h5A, 4'd1, 32'h0};
        tbl[13] = '{L, H, S,     H, 8'h77, H, L, L, 8'h00, 4'd0, S};
        tbl[14] = '{L, L, 32'h0, L, 8'h00, H, L, L, 8'h00, 4'd0, S};
        tbl[15] = '{L, L, 32'h0, L, 8'h00, L, H, L, 8'h00, 4'd0, S};
        tbl[16] = '{H, L, 32'h0, H, 8'h00, L, L, L, 8'h00, 4'd0, 32'h0};
        tbl[17] = '{L, L, 32'h0, H, 8'h00, L, L, L, 8'h00, 4'd0, 32'h0};
        tbl[18] = '{L, L, 32'h0, L, 8'h00, L, H, L, 8'h00, 4'd0, 32'h0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            seed_load = tbl[i].sl;
            seed_in   = tbl[i].seed;
            prg_done  = tbl[i].done;
            prg_value = tbl[i].val;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_start", i), 32'(prg_start), 32'(tbl[i].e_start));
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("t%0d_seed", i), prg_seed, tbl[i].e_seed);
            chk($sformatf("t%0d_err", i), 32'(timeout_err), 32'h0);
            if (tbl[i].e_valid || tbl[i].rst)
                chk($sformatf("t%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
        end

        // ---------------- fill ----------------
        @(negedge clk);
        model_on = 1'b1;
        do_reset();
        starts = 0;
        reseed(32'd2682981917);
        wait_cnt(8, 150, "fill_count");
        chk("fill_starts", 32'(starts), 32'd8);
        s0 = starts;
        repeat (20) step();
        chk("full_no_start", 32'(starts - s0), 32'd0);
        chk("full_count", 32'(count), 32'd8);
        tmp = xs(32'd2682981917);
        chk("fill_first", 32'(out_data), 32'(tmp[7:0]));

        // ---------------- drain and refill ----------------
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd5);
        wait_cnt(8, 100, "refill_count");
        chk("refill_sb", 32'(count), 32'(sb.size()));

        // ---------------- push and pop on the same edge ----------------
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            if (prg_done && count == 4'd4) begin
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                chk("pushpop_count", 32'(count), 32'd4);
                ok = 1'b1;
            end else begin
                out_ready = (count > 4'd4);
                step();
                n++;
            end
        end
        out_ready = 1'b0;
        chk("pushpop_reached", 32'(ok), 32'd1);
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;

        // ---------------- reseed mid-WAIT ----------------
        n = 0;
        while (!prg_start && n < 50) begin
            step();
            n++;
        end
        chk("reseed_req_seen", 32'(prg_start), 32'd1);
        step();
        reseed(32'd1928682902);
        chk("reseed_seed", prg_seed, 32'd1928682902);
        chk("reseed_count", 32'(count), 32'd0);
        chk("reseed_valid", 32'(out_valid), 32'd0);
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        tmp = xs(32'd1928682902);
        chk("reseed_first", 32'(out_data), 32'(tmp[7:0]));

        // ---------------- stuck done ----------------
        hold_len = 5;
        n = 0;
        while (!prg_done && n < 50) begin
            step();
            n++;
        end
        chk("stuck_done_seen", 32'(prg_done), 32'd1);
        c0 = 32'(count);
        s0 = starts;
        n  = 0;
        while (prg_done && n < 20) begin
            step();
            n++;
        end
        chk("stuck_no_start", 32'(starts - s0), 32'd0);
        chk("stuck_one_byte", 32'(count), 32'(c0 + 1));
        hold_len = 1;

        // ---------------- hung generator ----------------
        do_reset();
        chk("tmo_reset_err", 32'(timeout_err), 32'd0);
        hang = 1'b1;
        n = 0;
        while (!prg_start && n < 10) begin
            step();
            n++;
        end
        chk("tmo_req_seen", 32'(prg_start), 32'd1);
        n = 0;
        while (!timeout_err && n < 30) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd11);
        n2 = 0;
        while (!prg_start && n2 < 5) begin
            step();
            n2++;
        end
        chk("tmo_retry", 32'(n2 >= 1 && n2 <= 2), 32'd1);
        step();
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        chk("tmo_no_push", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
